// File: rtl/acc_4b.sv
// acc_4b: registered accumulator stage with a single-entry output buffer.
// Each accepted operand/op updates the accumulator (acc) and the carry/borrow flag (cy).
// The new result is latched into the output buffer, so back-to-back ops chain through
// acc with no stall. The valid/ready handshake on both sides lets a downstream stall
// back-pressure upstream.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand/op presented
//   in_ready   block can accept this cycle (combinational: !out_valid || out_ready)
//   in_op      operation code (LOAD/ADD/SUB/AND/OR/XOR/NOT/CLR)
//   in_data    operand
//   out_valid  result buffer full
//   out_ready  consumer takes the result this cycle
//   out_data   accumulator value after the op
//   out_carry  carry/borrow flag of the op
//   out_zero   registered out_data == 0
module acc_4b #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    localparam logic [2:0] OpLoad = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpSub  = 3'b010;
    localparam logic [2:0] OpAnd  = 3'b011;
    localparam logic [2:0] OpOr   = 3'b100;
    localparam logic [2:0] OpXor  = 3'b101;
    localparam logic [2:0] OpNot  = 3'b110;
    localparam logic [2:0] OpClr  = 3'b111;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_acc;
    logic             alu_cy;

    // Pass-through ready: a pop in the same cycle frees the buffer for a push.
    assign in_ready = (state_q == StEmpty) || out_ready;
    assign accept   = in_valid && in_ready;

    // Extended by one bit so the MSB of the result is the carry-out or the borrow.
    assign sum  = {1'b0, acc_q} + {1'b0, in_data};
    assign diff = {1'b0, acc_q} - {1'b0, in_data};

    always_comb begin
        alu_acc = acc_q;
        alu_cy  = 1'b0;
        unique case (in_op)
            OpLoad: alu_acc = in_data;
            OpAdd: begin
                alu_acc = sum[WIDTH-1:0];
                alu_cy  = sum[WIDTH];
            end
            OpSub: begin
                alu_acc = diff[WIDTH-1:0];
                alu_cy  = diff[WIDTH];
            end
            OpAnd: alu_acc = acc_q & in_data;
            OpOr:  alu_acc = acc_q | in_data;
            OpXor: alu_acc = acc_q ^ in_data;
            OpNot: alu_acc = ~acc_q;
            OpClr: alu_acc = '0;
            default: alu_acc = acc_q;
        endcase
    end

    // Next-state logic for the output buffer and the accumulator.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cy_d    = cy_q;
        data_d  = data_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        if (accept) begin
            acc_d   = alu_acc;
            cy_d    = alu_cy;
            data_d  = alu_acc;
            carry_d = alu_cy;
            zero_d  = (alu_acc == '0);
        end
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (out_ready && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            acc_q   <= '0;
            cy_q    <= 1'b0;
            data_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cy_q    <= cy_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = data_q;
    assign out_carry = carry_q;
    assign out_zero  = zero_q;

endmodule
